game_timer_overlay: RTL and testbench

GAME_TIMER_OVERLAY -- requirements
Module: game_timer_overlay

---
 rtl/game_timer_overlay_pkg.sv | 43 ++++
 rtl/vga_if.sv | 13 +
 rtl/bcd_mmss_counter.sv | 36 +++
 rtl/game_timer_overlay.sv | 120 ++++++++++++
 tb/tb_game_timer_overlay.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_timer_overlay_pkg.sv
// Shared game definitions: glyph geometry, ASCII codes, the BCD MM:SS time type
// and the VGA timing bundle used for pipeline staging.
package game_timer_overlay_pkg;

  localparam int CHAR_W    = 8;
  localparam int CHAR_H    = 16;
  localparam int NUM_CHARS = 5;

  localparam logic [6:0] ASCII_ZERO  = 7'h30;
  localparam logic [6:0] ASCII_COLON = 7'h3A;

  typedef struct packed {
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
  } bcd_time_t;

  localparam bcd_time_t TIME_MAX = 16'h5959;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_sig_t;

  // Character code for slot idx of "MM:SS"
  function automatic logic [6:0] char_code(input bcd_time_t t, input logic [2:0] idx);
    case (idx)
      3'd0:    return ASCII_ZERO + {3'b000, t.m1};
      3'd1:    return ASCII_ZERO + {3'b000, t.m0};
      3'd2:    return ASCII_COLON;
      3'd3:    return ASCII_ZERO + {3'b000, t.s1};
      3'd4:    return ASCII_ZERO + {3'b000, t.s0};
      default: return 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing + colour bundle passed between drawing layers.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/bcd_mmss_counter.sv
// BCD minutes:seconds counter, one second per tick, saturating at 59:59.
module bcd_mmss_counter
  import game_timer_overlay_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      clear,
  input  logic      tick,
  output bcd_time_t value
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      value <= '0;
    end else if (tick && (value != TIME_MAX)) begin
      // Not at 59:59, so a carry into m1 can only ever reach 5.
      if (value.s0 != 4'd9) begin
        value.s0 <= value.s0 + 4'd1;
      end else begin
        value.s0 <= 4'd0;
        if (value.s1 != 4'd5) begin
          value.s1 <= value.s1 + 4'd1;
        end else begin
          value.s1 <= 4'd0;
          if (value.m0 != 4'd9) begin
            value.m0 <= value.m0 + 4'd1;
          end else begin
            value.m0 <= 4'd0;
            value.m1 <= value.m1 + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/game_timer_overlay.sv
// Elapsed-time "MM:SS" text overlay on the VGA stream; two-stage pipeline,
// font ROM lives in the parent and is read through addr/char_line_pixels.
module game_timer_overlay
  import game_timer_overlay_pkg::*;
#(
  parameter int          CLK_HZ  = 65_000_000,
  parameter int          TXT_X   = 900,
  parameter int          TXT_Y   = 16,
  parameter logic [11:0] TXT_RGB = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        clear,
  vga_if.in           in,
  vga_if.out          out,
  output logic [10:0] addr,
  input  logic [7:0]  char_line_pixels,
  output logic [15:0] time_bcd
);

  localparam int              PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [11:0]     X_LO      = 12'(TXT_X);
  localparam logic [11:0]     X_HI      = 12'(TXT_X + NUM_CHARS * CHAR_W);
  localparam logic [11:0]     Y_LO      = 12'(TXT_Y);
  localparam logic [11:0]     Y_HI      = 12'(TXT_Y + CHAR_H);

  logic [PW-1:0] presc;
  logic          tick;
  bcd_time_t     cur;
  bcd_time_t     snap;

  assign tick = run && (presc == PRESC_MAX);

  always_ff @(posedge clk) begin
    if (rst || clear)
      presc <= '0;
    else if (run)
      presc <= tick ? '0 : presc + 1'b1;
  end

  bcd_mmss_counter u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .tick  (tick),
    .value (cur)
  );

  assign time_bcd = cur;

  // Latch once at the top-left pixel so a whole frame shows the same value.
  always_ff @(posedge clk) begin
    if (rst)
      snap <= '0;
    else if (in.vcount == 11'd0 && in.hcount == 11'd0)
      snap <= cur;
  end

  // Bounds in 12 bits so no coordinate can wrap into the window.
  logic       win;
  logic [5:0] dx;
  logic [3:0] dy;
  logic [6:0] code;

  assign win  = ({1'b0, in.hcount} >= X_LO) && ({1'b0, in.hcount} < X_HI) &&
                ({1'b0, in.vcount} >= Y_LO) && ({1'b0, in.vcount} < Y_HI);
  assign dx   = in.hcount[5:0] - X_LO[5:0];
  assign dy   = in.vcount[3:0] - Y_LO[3:0];
  assign code = char_code(snap, dx[5:3]);

  vga_sig_t   s1;
  logic       s1_win;
  logic [2:0] s1_col;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '0;
      s1_win <= 1'b0;
      s1_col <= '0;
      addr   <= '0;
    end else begin
      s1.hcount <= in.hcount;
      s1.vcount <= in.vcount;
      s1.hsync  <= in.hsync;
      s1.vsync  <= in.vsync;
      s1.hblnk  <= in.hblnk;
      s1.vblnk  <= in.vblnk;
      s1.rgb    <= in.rgb;
      s1_win    <= win;
      s1_col    <= dx[2:0];
      addr      <= win ? {code, dy} : 11'd0;
    end
  end

  logic pix;
  assign pix = char_line_pixels[3'd7 - s1_col];

  always_ff @(posedge clk) begin
    if (rst) begin
      out.hcount <= '0;
      out.vcount <= '0;
      out.hsync  <= 1'b0;
      out.vsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.hcount <= s1.hcount;
      out.vcount <= s1.vcount;
      out.hsync  <= s1.hsync;
      out.vsync  <= s1.vsync;
      out.hblnk  <= s1.hblnk;
      out.vblnk  <= s1.vblnk;
      out.rgb    <= (s1_win && !s1.hblnk && !s1.vblnk && pix) ? TXT_RGB : s1.rgb;
    end
  end

endmodule

// File: tb/tb_game_timer_overlay.sv
// Directed bench: timer model in seconds, pixel scoreboard queue for the overlay.
module tb_game_timer_overlay;

  localparam int          CLK_HZ  = 10;
  localparam int          TXT_X   = 900;
  localparam int          TXT_Y   = 16;
  localparam logic [11:0] TXT_RGB = 12'hF0F;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        clear = 1'b0;
  logic [10:0] addr;
  logic [7:0]  char_line_pixels;
  logic [15:0] time_bcd;

  vga_if vin ();
  vga_if vout ();

  always #5 clk = ~clk;

  game_timer_overlay #(
    .CLK_HZ  (CLK_HZ),
    .TXT_X   (TXT_X),
    .TXT_Y   (TXT_Y),
    .TXT_RGB (TXT_RGB)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .run              (run),
    .clear            (clear),
    .in               (vin),
    .out              (vout),
    .addr             (addr),
    .char_line_pixels (char_line_pixels),
    .time_bcd         (time_bcd)
  );

  // Font ROM stand-in, read on the registered address.
  function automatic logic [7:0] rom(input logic [10:0] a);
    if (a == {7'h32, 4'h5}) return 8'h80;
    return a[7:0] ^ {a[10:4], 1'b1};
  endfunction

  assign char_line_pixels = rom(addr);

  int         vectors = 0;
  int         errors  = 0;
  pix_t       exp_q[$];
  logic [15:0] m_time = '0;
  logic [15:0] m_snap = '0;
  int          m_presc = 0;

  function automatic int to_sec(input logic [15:0] t);
    return int'(t[15:12]) * 600 + int'(t[11:8]) * 60 + int'(t[7:4]) * 10 + int'(t[3:0]);
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    int m = s / 60;
    int ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [15:0] sec_inc(input logic [15:0] t);
    int s = to_sec(t);
    if (s < 3599) s++;
    return to_bcd(s);
  endfunction

  function automatic pix_t mk(input int h, input int v, input logic hs, input logic vs,
                              input logic hb, input logic vb, input logic [11:0] rgb);
    pix_t p;
    p.h = 11'(h); p.v = 11'(v); p.hs = hs; p.vs = vs; p.hb = hb; p.vb = vb; p.rgb = rgb;
    return p;
  endfunction

  function automatic logic [10:0] m_addr(input pix_t p, input logic [15:0] snap);
    int h = int'(p.h);
    int v = int'(p.v);
    if (h >= TXT_X && h < TXT_X + 40 && v >= TXT_Y && v < TXT_Y + 16) begin
      int c = (h - TXT_X) / 8;
      logic [3:0] d;
      logic [6:0] code;
      case (c)
        0:       d = snap[15:12];
        1:       d = snap[11:8];
        3:       d = snap[7:4];
        default: d = snap[3:0];
      endcase
      code = (c == 2) ? 7'h3A : 7'h30 + {3'b000, d};
      return {code, 4'(v - TXT_Y)};
    end
    return 11'd0;
  endfunction

  function automatic pix_t m_out(input pix_t p, input logic [15:0] snap);
    pix_t o = p;
    logic [10:0] a = m_addr(p, snap);
    logic [7:0] g = rom(a);
    int col = 0;
    if (a != 11'd0) begin
      col = (int'(p.h) - TXT_X) % 8;
      if (!p.hb && !p.vb && g[7 - col]) o.rgb = TXT_RGB;
    end
    return o;
  endfunction

  function automatic pix_t out_now();
    return {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb};
  endfunction

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input pix_t p);
    vin.hcount = p.h; vin.vcount = p.v; vin.hsync = p.hs; vin.vsync = p.vs;
    vin.hblnk = p.hb; vin.vblnk = p.vb; vin.rgb = p.rgb;
  endtask

  // One pixel: addr checked after one edge, out checked two edges after drive.
  task automatic stream(input pix_t p);
    logic [10:0] ea;
    drive(p);
    exp_q.push_back(m_out(p, m_snap));
    ea = m_addr(p, m_snap);
    if (p.h == 11'd0 && p.v == 11'd0) m_snap = m_time;
    cyc();
    check("addr", 40'(addr), 40'(ea));
    if (exp_q.size() == 2) check("out", 40'(out_now()), 40'(exp_q.pop_front()));
  endtask

  task automatic flush();
    stream(mk(5, 300, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000));
    exp_q.delete();
  endtask

  task automatic clk_step(input logic r, input logic c);
    run = r;
    clear = c;
    cyc();
    if (c) begin
      m_time = '0;
      m_presc = 0;
    end else if (r) begin
      if (m_presc == CLK_HZ - 1) begin
        m_presc = 0;
        m_time = sec_inc(m_time);
      end else begin
        m_presc++;
      end
    end
    clear = 1'b0;
  endtask

  task automatic clocks(input int n, input logic r);
    for (int i = 0; i < n; i++) clk_step(r, 1'b0);
    run = 1'b0;
  endtask

  task automatic check_timer(input string tag);
    check({tag, "_time"}, 40'(time_bcd), 40'(m_time));
    check({tag, "_presc"}, 40'(dut.presc), 40'(m_presc));
  endtask

  task automatic row(input int v);
    for (int h = TXT_X - 1; h <= TXT_X + 40; h++)
      stream(mk(h, v, h[0], 1'b0, (h % 11) == 0, 1'b0, 12'(h * 7 + v)));
  endtask

  initial begin
    // Reset held with busy inputs
    drive(mk(5, 300, 1'b1, 1'b1, 1'b0, 1'b0, 12'hABC));
    repeat (3) cyc();
    check("rst_out", 40'(out_now()), 40'd0);
    check("rst_time", 40'(time_bcd), 40'd0);
    check("rst_addr", 40'(addr), 40'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++)
      stream(mk(100 + i, 300 + i, i[0], i[1], i[2], 1'b0, 12'(12'h123 * (i + 1))));
    flush();

    // Counting and hold
    clocks(610, 1'b1);
    check("count_0101", 40'(time_bcd), 40'h0101);
    check_timer("count");
    clocks(3, 1'b1);
    clocks(50, 1'b0);
    check_timer("hold");

    // Clear colliding with a tick at 00:09
    clk_step(1'b0, 1'b1);
    check_timer("clear");
    clocks(99, 1'b1);
    check("pre_tick_0009", 40'(time_bcd), 40'h0009);
    check("pre_tick_presc", 40'(dut.presc), 40'(CLK_HZ - 1));
    clk_step(1'b1, 1'b1);
    run = 1'b0;
    check("clr_tick_time", 40'(time_bcd), 40'h0000);
    check("clr_tick_presc", 40'(dut.presc), 40'd0);

    // Overlay at 12:34
    clocks(7540, 1'b1);
    check("time_1234", 40'(time_bcd), 40'h1234);
    stream(mk(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h001));
    stream(mk(TXT_X + 8, TXT_Y + 5, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0));
    check("addr_glyph", 40'(addr), 40'({7'h32, 4'h5}));
    stream(mk(TXT_X + 40, TXT_Y + 5, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0));
    check("rgb_text", 40'(vout.rgb), 40'(TXT_RGB));
    stream(mk(TXT_X + 41, TXT_Y + 5, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F1));
    check("rgb_right_edge", 40'(vout.rgb), 40'h0F0);
    row(TXT_Y - 1);
    row(TXT_Y);
    row(TXT_Y + 5);
    row(TXT_Y + 15);
    row(TXT_Y + 16);
    stream(mk(TXT_X + 8, 2047, 1'b0, 1'b0, 1'b0, 1'b0, 12'h555));
    flush();

    // Tick mid-frame: display keeps 12:34 until next frame origin
    clocks(10, 1'b1);
    check("time_1235", 40'(time_bcd), 40'h1235);
    stream(mk(TXT_X + 32, TXT_Y + 3, 1'b0, 1'b0, 1'b0, 1'b0, 12'h222));
    check("no_tear_digit", 40'(addr), 40'({7'h34, 4'h3}));
    stream(mk(0, 1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000));
    stream(mk(1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000));
    stream(mk(TXT_X + 32, TXT_Y + 3, 1'b0, 1'b0, 1'b0, 1'b0, 12'h222));
    check("no_snap_offorigin", 40'(addr), 40'({7'h34, 4'h3}));
    stream(mk(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000));
    stream(mk(TXT_X + 32, TXT_Y + 3, 1'b0, 1'b0, 1'b0, 1'b0, 12'h222));
    check("new_frame_digit", 40'(addr), 40'({7'h35, 4'h3}));
    row(TXT_Y + 3);
    flush();

    // Saturation
    clk_step(1'b0, 1'b1);
    clocks(35980, 1'b1);
    check("time_5958", 40'(time_bcd), 40'h5958);
    clocks(30, 1'b1);
    check("sat_5959", 40'(time_bcd), 40'h5959);
    clocks(23, 1'b1);
    check_timer("sat_hold");

    // Reset mid-frame beats run, clear and the frame snapshot
    stream(mk(TXT_X, TXT_Y, 1'b1, 1'b1, 1'b0, 1'b0, 12'h777));
    stream(mk(TXT_X + 1, TXT_Y, 1'b1, 1'b1, 1'b0, 1'b0, 12'h778));
    exp_q.delete();
    drive(mk(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h999));
    rst = 1'b1;
    run = 1'b1;
    clear = 1'b1;
    cyc();
    check("rst2_out", 40'(out_now()), 40'd0);
    check("rst2_time", 40'(time_bcd), 40'd0);
    check("rst2_presc", 40'(dut.presc), 40'd0);
    check("rst2_addr", 40'(addr), 40'd0);
    check("rst2_snap", 40'(dut.snap), 40'd0);
    rst = 1'b0;
    run = 1'b0;
    clear = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
